// File: rtl/axi_lite_reg_pkg.sv
// Shared definitions for the MM2S AXI4-Lite configuration register file:
// register offsets, bit positions, response codes and the address decoder.
package axi_lite_reg_pkg;

  localparam logic [31:0] OFF_CR     = 32'h0000_0000;
  localparam logic [31:0] OFF_SR     = 32'h0000_0004;
  localparam logic [31:0] OFF_SA     = 32'h0000_0018;
  localparam logic [31:0] OFF_SA_MSB = 32'h0000_001C;
  localparam logic [31:0] OFF_LENGTH = 32'h0000_0028;

  localparam int BIT_RS        = 0;
  localparam int BIT_RESET     = 2;
  localparam int BIT_IOC_IRQEN = 12;
  localparam int BIT_IOC_IRQ   = 12;
  localparam int BIT_HALTED    = 0;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef enum logic [2:0] {
    SEL_CR     = 3'd0,
    SEL_SR     = 3'd1,
    SEL_SA     = 3'd2,
    SEL_SA_MSB = 3'd3,
    SEL_LENGTH = 3'd4,
    SEL_NONE   = 3'd5
  } reg_sel_e;

  // Byte-lane bits of the address are ignored; anything unmapped is SEL_NONE.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    logic [31:0] word;
    word = addr & ~32'h0000_0003;
    case (word)
      OFF_CR:     return SEL_CR;
      OFF_SR:     return SEL_SR;
      OFF_SA:     return SEL_SA;
      OFF_SA_MSB: return SEL_SA_MSB;
      OFF_LENGTH: return SEL_LENGTH;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave holding the MM2S control, source address and length
// registers, plus a status register with a sticky completion interrupt.
module axi_lite_reg_slave
  import axi_lite_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 26
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  input  logic                  s_axi_lite_awvalid,
  output logic                  s_axi_lite_awready,
  input  logic [ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                  s_axi_lite_wvalid,
  output logic                  s_axi_lite_wready,
  input  logic [DATA_WIDTH-1:0] s_axi_lite_wdata,
  output logic                  s_axi_lite_bvalid,
  input  logic                  s_axi_lite_bready,
  output logic [1:0]            s_axi_lite_bresp,
  input  logic                  s_axi_lite_arvalid,
  output logic                  s_axi_lite_arready,
  input  logic [ADDR_WIDTH-1:0] s_axi_lite_araddr,
  output logic                  s_axi_lite_rvalid,
  input  logic                  s_axi_lite_rready,
  output logic [DATA_WIDTH-1:0] s_axi_lite_rdata,
  output logic [1:0]            s_axi_lite_rresp,
  output logic                  ctrl_run,
  output logic                  ctrl_soft_reset,
  output logic                  xfer_start,
  output logic [63:0]           src_addr,
  output logic [LEN_WIDTH-1:0]  xfer_len,
  input  logic                  dp_halted,
  input  logic                  dp_ioc,
  output logic                  introut
);

  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  bvalid_q, bvalid_d;
  resp_e                 bresp_q, bresp_d;

  logic                  rs_q, rs_d;
  logic                  irqen_q, irqen_d;
  logic                  ioc_q, ioc_d;
  logic [DATA_WIDTH-1:0] sa_q, sa_d;
  logic [DATA_WIDTH-1:0] sa_msb_q, sa_msb_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  soft_rst_q, soft_rst_d;
  logic                  xfer_start_q, xfer_start_d;

  rd_state_e             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_e                 rresp_q, rresp_d;

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  reg_sel_e              wr_sel_s, rd_sel_s;
  logic [DATA_WIDTH-1:0] rd_val_s;

  assign s_axi_lite_awready = !axi_reset && !aw_held_q && !bvalid_q;
  assign s_axi_lite_wready  = !axi_reset && !w_held_q && !bvalid_q;
  assign s_axi_lite_bvalid  = bvalid_q;
  assign s_axi_lite_bresp   = bresp_q;
  assign s_axi_lite_rdata   = rdata_q;
  assign s_axi_lite_rresp   = rresp_q;

  assign ctrl_run        = rs_q;
  assign ctrl_soft_reset = soft_rst_q;
  assign xfer_start      = xfer_start_q;
  assign src_addr        = {sa_msb_q, sa_q};
  assign xfer_len        = len_q;
  assign introut         = ioc_q && irqen_q;

  // Bypass the holding registers so a same-cycle AW+W commits immediately.
  always_comb begin
    aw_hs_s   = s_axi_lite_awvalid && s_axi_lite_awready;
    w_hs_s    = s_axi_lite_wvalid && s_axi_lite_wready;
    wr_addr_s = aw_held_q ? awaddr_q : s_axi_lite_awaddr;
    wr_data_s = w_held_q ? wdata_q : s_axi_lite_wdata;
    commit_s  = (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s) && !bvalid_q;
    wr_sel_s  = decode_addr(32'(wr_addr_s));

    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (commit_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (wr_sel_s == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (aw_hs_s) begin
        aw_held_d = 1'b1;
        awaddr_d  = s_axi_lite_awaddr;
      end else begin
        aw_held_d = aw_held_q;
      end
      if (w_hs_s) begin
        w_held_d = 1'b1;
        wdata_d  = s_axi_lite_wdata;
      end else begin
        w_held_d = w_held_q;
      end
      if (bvalid_q && s_axi_lite_bready) begin
        bvalid_d = 1'b0;
      end else begin
        bvalid_d = bvalid_q;
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Register file update; the soft-reset pulse clears config one edge later.
  always_comb begin
    rs_d         = rs_q;
    irqen_d      = irqen_q;
    sa_d         = sa_q;
    sa_msb_d     = sa_msb_q;
    len_d        = len_q;
    soft_rst_d   = commit_s && (wr_sel_s == SEL_CR) && wr_data_s[BIT_RESET];
    xfer_start_d = commit_s && (wr_sel_s == SEL_LENGTH) && rs_q;

    if (soft_rst_q) begin
      rs_d     = 1'b0;
      irqen_d  = 1'b0;
      sa_d     = '0;
      sa_msb_d = '0;
      len_d    = '0;
    end else if (commit_s) begin
      case (wr_sel_s)
        SEL_CR: begin
          rs_d    = wr_data_s[BIT_RS];
          irqen_d = wr_data_s[BIT_IOC_IRQEN];
        end
        SEL_SA:     sa_d     = wr_data_s;
        SEL_SA_MSB: sa_msb_d = wr_data_s;
        SEL_LENGTH: len_d    = wr_data_s[LEN_WIDTH-1:0];
        default:    len_d    = len_q;
      endcase
    end else begin
      len_d = len_q;
    end

    if (dp_ioc) begin
      ioc_d = 1'b1;
    end else if (soft_rst_q ||
                 (commit_s && (wr_sel_s == SEL_SR) && wr_data_s[BIT_IOC_IRQ])) begin
      ioc_d = 1'b0;
    end else begin
      ioc_d = ioc_q;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      rs_q         <= 1'b0;
      irqen_q      <= 1'b0;
      ioc_q        <= 1'b0;
      sa_q         <= '0;
      sa_msb_q     <= '0;
      len_q        <= '0;
      soft_rst_q   <= 1'b0;
      xfer_start_q <= 1'b0;
    end else begin
      rs_q         <= rs_d;
      irqen_q      <= irqen_d;
      ioc_q        <= ioc_d;
      sa_q         <= sa_d;
      sa_msb_q     <= sa_msb_d;
      len_q        <= len_d;
      soft_rst_q   <= soft_rst_d;
      xfer_start_q <= xfer_start_d;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      rd_state_q <= R_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s_axi_lite_arvalid && !axi_reset) begin
          rd_state_d = R_DATA;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (s_axi_lite_rready) begin
          rd_state_d = R_IDLE;
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_lite_arready = 1'b0;
    s_axi_lite_rvalid  = 1'b0;
    case (rd_state_q)
      R_IDLE:  s_axi_lite_arready = !axi_reset;
      R_DATA:  s_axi_lite_rvalid  = 1'b1;
      default: s_axi_lite_rvalid  = 1'b0;
    endcase
  end

  // Read data is sampled from the current (pre-commit) register values.
  always_comb begin
    ar_hs_s  = s_axi_lite_arvalid && s_axi_lite_arready;
    rd_sel_s = decode_addr(32'(s_axi_lite_araddr));
    rd_val_s = '0;
    case (rd_sel_s)
      SEL_CR: begin
        rd_val_s[BIT_RS]        = rs_q;
        rd_val_s[BIT_IOC_IRQEN] = irqen_q;
      end
      SEL_SR: begin
        rd_val_s[BIT_HALTED]  = dp_halted;
        rd_val_s[BIT_IOC_IRQ] = ioc_q;
      end
      SEL_SA:     rd_val_s = sa_q;
      SEL_SA_MSB: rd_val_s = sa_msb_q;
      SEL_LENGTH: rd_val_s = DATA_WIDTH'(len_q);
      default:    rd_val_s = '0;
    endcase

    if (ar_hs_s) begin
      rdata_d = rd_val_s;
      rresp_d = (rd_sel_s == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else begin
      rdata_d = rdata_q;
      rresp_d = rresp_q;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

endmodule

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

AXI4-Lite slave register file that terminates the DMA configuration port and converts bus writes/reads into control, address and length registers for the MM2S datapath. Sits directly downstream of the AXI-Lite register-configuration master. Write address and write data are accepted independently and in either order. Status from the datapath is folded back into a readable status register and an interrupt line.

## Interface
- ADDR_WIDTH, 10, AXI-Lite byte address width
- DATA_WIDTH, 32, AXI-Lite data width (only 32 supported)
- LEN_WIDTH, 26, implemented bits of LENGTH register
- axi_aclk  in  1  clock
- axi_reset  in  1  reset; asynchronous, active-high
- s_axi_lite_awvalid / awready  in / out  1  write-address handshake
- s_axi_lite_awaddr  in  ADDR_WIDTH  write byte address
- s_axi_lite_wvalid / wready  in / out  1  write-data handshake
- s_axi_lite_wdata  in  DATA_WIDTH  write data (no strobes; full-word writes)
- s_axi_lite_bvalid / bready  out / in  1  write-response handshake
- s_axi_lite_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_lite_arvalid / arready  in / out  1  read-address handshake
- s_axi_lite_araddr  in  ADDR_WIDTH  read byte address
- s_axi_lite_rvalid / rready  out / in  1  read-data handshake
- s_axi_lite_rdata  out  DATA_WIDTH  read data
- s_axi_lite_rresp  out  2  00 OKAY, 10 SLVERR
- ctrl_run  out  1  CR.RS
- ctrl_soft_reset  out  1  one-cycle pulse on write of CR bit2 = 1
- xfer_start  out  1  one-cycle pulse on LENGTH write while ctrl_run = 1
- src_addr  out  64  {SA_MSB, SA}
- xfer_len  out  LEN_WIDTH  LENGTH register
- dp_halted  in  1  datapath halted status
- dp_ioc  in  1  one-cycle completion pulse
- introut  out  1  SR.IOC_Irq & CR.IOC_IrqEn

## Operation
- Register map (byte offsets; addr[1:0] ignored): 0x00 CR (RW: bit0 RS, bit2 Reset self-clearing reads 0, bit12 IOC_IrqEn); 0x04 SR (bit0 Halted RO = dp_halted, bit12 IOC_Irq W1C); 0x18 SA RW; 0x1C SA_MSB RW; 0x28 LENGTH RW, bits above LEN_WIDTH read 0. Unimplemented bits read 0.
- Any other offset: write discarded, bresp = 10; read returns rdata = 0, rresp = 10.
- Write: AW and W captured into holding registers (aw_held, w_held). Commit occurs in the cycle both are held and bvalid = 0; commit clears both holds and sets bvalid next edge with bresp.
- Read FSM: R_IDLE (arready = 1) -> AR handshake -> R_DATA (rvalid = 1, rdata/rresp registered at handshake) -> rready -> R_IDLE.
- Soft reset pulse (CR bit2 written 1) clears CR, SA, SA_MSB, LENGTH, SR.IOC_Irq next edge; outstanding bus handshakes are unaffected.
- SR.IOC_Irq: set by dp_ioc; cleared by write of 1 to SR bit12. Simultaneous set and clear -> set wins.

## Timing
- Reset values: all awready/wready/arready = 0 during reset, 1 in first cycle after; bvalid, rvalid, bresp, rresp, rdata, ctrl_*, xfer_start, src_addr, xfer_len, introut = 0.
- awready = !aw_held & !bvalid; wready = !w_held & !bvalid; arready = !rvalid.
- AW and W in same cycle: commit that cycle's edge +1, bvalid at cycle+1 (1-cycle write latency). Separate: bvalid one cycle after the later handshake.
- bvalid holds until bready; new AW/W not accepted while bvalid = 1.
- Read latency: rvalid the cycle after AR handshake; rdata stable until rready.
- Read and write commit to same register in same cycle: read returns pre-write value.
- xfer_start and ctrl_soft_reset assert the cycle after commit, exactly one cycle.
- Asynchronous reset mid-transaction drops all held/pending state; no response issued.

## Structure
- Package axi_lite_reg_pkg: register offset localparams, bit-position constants (RS, RESET, IOC_IRQEN, IOC_IRQ, HALTED), resp enum {OKAY=2'b00, SLVERR=2'b10}, read FSM state enum.
- Single module; no sub-modules. Address decode is a combinational function in the package shared by read and write paths.

## Test plan
- Write 0x0000_1001 to 0x00 with AW and W same cycle -> bvalid next cycle, bresp 00; read 0x00 -> 0x0000_1001, ctrl_run = 1.
- W sent 3 cycles before AW to 0x18 with 0xDEAD_BEEF -> bvalid one cycle after AW handshake; src_addr[31:0] = 0xDEAD_BEEF.
- With RS = 1 write 0x28 = 0xFFFF_FFFF -> xfer_start one-cycle pulse, read 0x28 returns 0x03FF_FFFF.
- Pulse dp_ioc with IrqEn = 1 -> introut = 1, SR reads 0x1000; write 0x1000 to 0x04 in same cycle as another dp_ioc -> bit stays 1; clear again alone -> introut = 0.
- Write/read 0x3FC -> bresp/rresp 10, rdata 0, no register changes; bready held low 5 cycles -> bvalid held, awready = 0 throughout.
- Assert axi_reset while bvalid pending -> bvalid drops immediately, all registers read 0 after release.
